// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-stage definitions: PC width, reset/BTB defaults, BTB entry layout.
package fetch_pc_unit_pkg;

    localparam int                  PC_WIDTH           = 32;
    localparam logic [PC_WIDTH-1:0] DEF_RESET_PC       = 32'h0000_0000;
    localparam int                  DEF_BTB_INDEX_BITS = 6;
    localparam int                  DEF_BTB_TAG_BITS   = 30 - DEF_BTB_INDEX_BITS;

    typedef struct packed {
        logic                        valid;
        logic [DEF_BTB_TAG_BITS-1:0] tag;
        logic [PC_WIDTH-3:0]         target;
    } btb_entry_t;

    function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] a);
        return {a[PC_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch PC unit bus: redirect/stall/BHT/BTB-update inputs and fetch/prediction outputs.
interface fetch_pc_unit_if;
    import fetch_pc_unit_pkg::*;

    logic                stall;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_PC;
    logic                predict_taken;
    logic                btb_update_enable;
    logic [PC_WIDTH-1:0] btb_update_PC;
    logic [PC_WIDTH-1:0] btb_update_target;
    logic [PC_WIDTH-1:0] lookup_PC;
    logic [PC_WIDTH-1:0] fetch_PC;
    logic                fetch_valid;
    logic                pred_taken_out;
    logic [PC_WIDTH-1:0] pred_target;

    modport master (
        output stall, redirect_valid, redirect_PC, predict_taken,
               btb_update_enable, btb_update_PC, btb_update_target,
        input  lookup_PC, fetch_PC, fetch_valid, pred_taken_out, pred_target
    );

    modport slave (
        input  stall, redirect_valid, redirect_PC, predict_taken,
               btb_update_enable, btb_update_PC, btb_update_target,
        output lookup_PC, fetch_PC, fetch_valid, pred_taken_out, pred_target
    );

endinterface

// File: rtl/fetch_pc_unit_btb_table.sv
// Direct-mapped tagged BTB: combinational read, synchronous write, async-cleared valid bits.
module btb_table
    import fetch_pc_unit_pkg::*;
#(
    parameter int IDX_W = DEF_BTB_INDEX_BITS,
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    input  logic [TAG_W-1:0] i_rd_tag,
    output logic             o_rd_hit,
    output logic [29:0]      o_rd_target,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic [29:0]      i_wr_target
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [29:0]        r_target [ENTRIES];

    // Only valid bits need reset; tag/target are meaningless until valid is set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_valid <= '0;
        else if (i_wr_en)
            r_valid[i_wr_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]    <= i_wr_tag;
            r_target[i_wr_idx] <= i_wr_target;
        end
    end

    // Read sees the array before this edge's write lands.
    assign o_rd_hit    = r_valid[i_rd_idx] & (r_tag[i_rd_idx] == i_rd_tag);
    assign o_rd_target = r_target[i_rd_idx];

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage next-PC generator: PC register, BTB lookup and redirect/stall/predict next-PC mux.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = DEF_RESET_PC,
    parameter int          BTB_INDEX_BITS = DEF_BTB_INDEX_BITS,
    parameter int          BTB_TAG_BITS   = 30 - BTB_INDEX_BITS
) (
    input  logic          clk,
    input  logic          rst,
    fetch_pc_unit_if.slave bus
);

    logic [PC_WIDTH-1:0]       r_pc;
    logic                      r_fetch_valid;

    logic [BTB_INDEX_BITS-1:0] w_rd_idx;
    logic [BTB_TAG_BITS-1:0]   w_rd_tag;
    logic [BTB_INDEX_BITS-1:0] w_wr_idx;
    logic [BTB_TAG_BITS-1:0]   w_wr_tag;
    logic                      w_btb_hit;
    logic [29:0]               w_btb_word;
    logic [PC_WIDTH-1:0]       w_btb_target;
    logic [PC_WIDTH-1:0]       w_pc_inc;
    logic                      w_pred;
    logic [PC_WIDTH-1:0]       w_next_pc;
    logic [1:0]                w_unused;

    assign w_rd_idx     = r_pc[BTB_INDEX_BITS+1:2];
    assign w_rd_tag     = r_pc[PC_WIDTH-1:BTB_INDEX_BITS+2];
    assign w_wr_idx     = bus.btb_update_PC[BTB_INDEX_BITS+1:2];
    assign w_wr_tag     = bus.btb_update_PC[PC_WIDTH-1:BTB_INDEX_BITS+2];
    assign w_unused     = bus.btb_update_PC[1:0] ^ bus.btb_update_target[1:0];

    btb_table #(
        .IDX_W (BTB_INDEX_BITS),
        .TAG_W (BTB_TAG_BITS)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .i_rd_idx    (w_rd_idx),
        .i_rd_tag    (w_rd_tag),
        .o_rd_hit    (w_btb_hit),
        .o_rd_target (w_btb_word),
        .i_wr_en     (bus.btb_update_enable),
        .i_wr_idx    (w_wr_idx),
        .i_wr_tag    (w_wr_tag),
        .i_wr_target (bus.btb_update_target[PC_WIDTH-1:2])
    );

    assign w_btb_target = {w_btb_word, 2'b00};
    assign w_pc_inc     = r_pc + 32'd4;
    // The BTB only supplies a target; the BHT alone decides direction.
    assign w_pred       = r_fetch_valid & w_btb_hit & bus.predict_taken;

    always_comb begin
        w_next_pc = w_pc_inc;
        if (bus.redirect_valid)
            w_next_pc = word_align(bus.redirect_PC);
        else if (bus.stall)
            w_next_pc = r_pc;
        else if (w_pred)
            w_next_pc = w_btb_target;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= word_align(RESET_PC);
            r_fetch_valid <= 1'b0;
        end else begin
            r_pc          <= w_next_pc;
            r_fetch_valid <= 1'b1;
        end
    end

    assign bus.lookup_PC      = r_pc;
    assign bus.fetch_PC       = r_pc;
    assign bus.fetch_valid    = r_fetch_valid;
    assign bus.pred_taken_out = w_pred;
    assign bus.pred_target    = w_pred ? w_btb_target : w_pc_inc;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus random traffic against a word-address BTB model.
module tb_fetch_pc_unit;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    fetch_pc_unit_if bus();

    fetch_pc_unit #(
        .RESET_PC       (32'h0000_0100),
        .BTB_INDEX_BITS (6),
        .BTB_TAG_BITS   (24)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: PC, fetch-valid, and a 64-slot table keyed by (pc/4)%64 holding the full branch PC.
    logic [31:0] m_pc;
    bit          m_valid;
    bit          m_bv   [int];
    logic [31:0] m_bpc  [int];
    logic [31:0] m_btgt [int];

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h100;
        m_valid = 0;
        m_bv.delete();
        m_bpc.delete();
        m_btgt.delete();
    endtask

    task automatic step(input bit s, input bit rv, input logic [31:0] rpc, input bit pt,
                        input bit ue, input logic [31:0] upc, input logic [31:0] utg);
        int          i;
        bit          e_hit;
        bit          e_pred;
        logic [31:0] e_tgt;
        @(negedge clk);
        bus.stall             = s;
        bus.redirect_valid    = rv;
        bus.redirect_PC       = rpc;
        bus.predict_taken     = pt;
        bus.btb_update_enable = ue;
        bus.btb_update_PC     = upc;
        bus.btb_update_target = utg;
        #1;
        i      = slot(m_pc);
        e_hit  = m_bv.exists(i) && ((m_bpc[i] / 4) == (m_pc / 4));
        e_pred = m_valid && e_hit && pt;
        e_tgt  = e_hit ? (m_btgt[i] & ~32'h3) : 32'h0;
        chk("lookup_PC", bus.lookup_PC, m_pc);
        chk("fetch_PC", bus.fetch_PC, m_pc);
        chk("fetch_valid", {31'b0, bus.fetch_valid}, {31'b0, m_valid});
        chk("pred_taken_out", {31'b0, bus.pred_taken_out}, {31'b0, e_pred});
        chk("pred_target", bus.pred_target, e_pred ? e_tgt : m_pc + 32'd4);
        @(posedge clk);
        if (rv)         m_pc = rpc & ~32'h3;
        else if (!s)    m_pc = e_pred ? e_tgt : m_pc + 32'd4;
        m_valid = 1;
        if (ue) begin
            m_bv[slot(upc)]   = 1;
            m_bpc[slot(upc)]  = upc;
            m_btgt[slot(upc)] = utg;
        end
    endtask

    task automatic run(input bit pt);
        step(0, 0, 0, pt, 0, 0, 0);
    endtask

    task automatic jump(input logic [31:0] pc);
        step(0, 1, pc, 0, 0, 0, 0);
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] tgt);
        step(1, 0, 0, 0, 1, pc, tgt);
    endtask

    task automatic after(input string tag, input logic [31:0] exp);
        #1 chk(tag, bus.fetch_PC, exp);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b0;
        bus.stall = 0; bus.redirect_valid = 0; bus.redirect_PC = 0; bus.predict_taken = 0;
        bus.btb_update_enable = 0; bus.btb_update_PC = 0; bus.btb_update_target = 0;
        model_reset();

        // Reset and free-running fetch
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc", bus.fetch_PC, 32'h100);
        chk("rst_valid", {31'b0, bus.fetch_valid}, 32'h0);
        #1 rst = 1'b1;
        run(1);
        #1 chk("first_valid", {31'b0, bus.fetch_valid}, 32'h1);
        after("pc_104", 32'h104);
        run(1);
        after("pc_108", 32'h108);

        // Cold BTB with predict_taken held high
        repeat (4) run(1);
        after("cold_pc", 32'h118);

        // Train 0x108 -> 0x200 and hit it
        train(32'h108, 32'h200);
        jump(32'h100);
        run(1);
        run(1);
        run(1);
        after("hit_next", 32'h200);
        jump(32'h108);
        run(0);
        after("hit_nt_next", 32'h10C);

        // Alias: same index, different tag, then overwrite
        jump(32'h208);
        run(1);
        after("alias_miss", 32'h20C);
        train(32'h208, 32'h300);
        jump(32'h108);
        run(1);
        after("overwritten_miss", 32'h10C);

        // Redirect beats stall and prediction; stall alone holds
        train(32'h108, 32'h200);
        jump(32'h108);
        step(1, 1, 32'h403, 1, 0, 0, 0);
        after("redir_over_stall", 32'h400);
        jump(32'h108);
        repeat (3) begin
            step(1, 0, 0, 1, 0, 0, 0);
            after("stall_hold", 32'h108);
        end

        // Same-cycle update of the looked-up index is not visible yet
        train(32'h208, 32'h300);
        jump(32'h108);
        step(0, 0, 0, 1, 1, 32'h108, 32'h200);
        after("same_cycle_miss", 32'h10C);
        jump(32'h108);
        run(1);
        after("later_hit", 32'h200);

        // Wrap
        jump(32'hFFFF_FFFC);
        run(1);
        after("wrap", 32'h0);

        // Random traffic on a small aliased PC window
        for (int k = 0; k < 400; k++) begin
            logic [31:0] rpc;
            logic [31:0] upc;
            rpc = 32'h100 + ($urandom_range(0, 1) << 8) + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
            upc = 32'h100 + ($urandom_range(0, 1) << 8) + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
            step($urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, rpc,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, upc,
                 32'h100 + ($urandom_range(0, 31) << 2) + $urandom_range(0, 3));
        end

        // Mid-operation async reset clears PC, valid and the BTB
        train(32'h120, 32'h180);
        #2 rst = 1'b0;
        #1;
        chk("midrst_pc", bus.fetch_PC, 32'h100);
        chk("midrst_valid", {31'b0, bus.fetch_valid}, 32'h0);
        chk("midrst_pred", {31'b0, bus.pred_taken_out}, 32'h0);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        jump(32'h120);
        run(1);
        after("btb_cleared", 32'h124);
        for (int k = 0; k < 100; k++)
            step($urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, 32'h100 + ($urandom_range(0, 15) << 2),
                 1, $urandom_range(0, 2) == 0, 32'h100 + ($urandom_range(0, 15) << 2),
                 32'h100 + ($urandom_range(0, 15) << 2));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL timeout got=running exp=finished");
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $fatal(1);
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Fetch-stage next-PC generator sitting directly upstream of the branch history table. Holds the fetch PC register and drives it out as lookup_PC. It owns a direct-mapped, tagged branch target buffer (BTB). Each cycle it combines BTB hit/target with the BHT's predict_taken to choose the next PC; execute-stage mispredict redirects and pipeline stalls override that choice.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC value loaded on reset
BTB_INDEX_BITS, 6, log2 of BTB entry count (64 entries); index = PC[BTB_INDEX_BITS+1:2]
BTB_TAG_BITS, 30-BTB_INDEX_BITS, tag = PC[31:BTB_INDEX_BITS+2]

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
stall  input  1  hold fetch PC (hazard or memory wait)
redirect_valid  input  1  execute-stage mispredict or jump correction
redirect_PC  input  32  corrected PC; bits [1:0] ignored
predict_taken  input  1  BHT prediction for lookup_PC (combinational return)
btb_update_enable  input  1  write a BTB entry (resolved taken branch or jump)
btb_update_PC  input  32  PC of the resolved branch
btb_update_target  input  32  resolved target; bits [1:0] ignored
lookup_PC  output  32  current fetch PC, sent to the BHT
fetch_PC  output  32  current fetch PC, sent to the instruction memory/decode stage
fetch_valid  output  1  fetch_PC is meaningful
pred_taken_out  output  1  this fetch was predicted taken (btb_hit & predict_taken)
pred_target  output  32  predicted next PC, carried down the pipe for mispredict check

Behaviour:
- Reset (rst=0, async):
  - PC reg <= RESET_PC.
  - fetch_valid <= 0.
  - All BTB valid bits <= 0. Tags and targets are don't-care.
- fetch_valid rises to 1 on the first posedge after rst deasserts and stays 1.
- lookup_PC = fetch_PC = PC reg, combinational from the register. PC[1:0] is always 2'b00.
- BTB lookup (combinational on PC reg):
  - btb_hit = valid[idx] & (tag[idx] == PC tag).
  - btb_target = {target[idx], 2'b00}.
- pred_taken_out = fetch_valid & btb_hit & predict_taken.
- pred_target = pred_taken_out ? btb_target : PC+4.
- Next-PC priority, applied at posedge:
  1. redirect_valid: PC <= {redirect_PC[31:2], 2'b00}.
  2. else if stall: PC holds.
  3. else if pred_taken_out: PC <= btb_target.
  4. else: PC <= PC+4. Wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Redirect wins over a simultaneous stall.
- BTB update at posedge when btb_update_enable=1:
  - Entry at idx(btb_update_PC) <= {valid=1, tag(btb_update_PC), btb_update_target[31:2]}.
  - Aliasing entries are overwritten (no replacement policy).
- Updates proceed regardless of stall or redirect.
- Same-cycle update and lookup of the same index: lookup uses the pre-update contents. The new entry is visible from the next cycle.
- BTB hit with predict_taken=0: fall through to PC+4. The BHT alone decides direction.
- BTB miss: PC+4 regardless of predict_taken.
- Reset asserted mid-operation: state is immediately forced to reset values. No partial update survives.

Decomposition:
- Shared pipeline package holds:
  - PC_WIDTH=32
  - RESET_PC default
  - BTB_INDEX_BITS default
  - a btb_entry_t typedef {valid, tag, target[31:2]}
- One sub-module: btb_table, holding the storage, the combinational read port and the synchronous write port with async valid clear.
- PC register and next-PC mux stay in fetch_pc_unit.

Test Plan:
- Reset: RESET_PC=32'h100, hold rst=0 then release -> fetch_PC=32'h100 and fetch_valid=0 in reset; first edge after release gives fetch_valid=1. Free-running fetch gives 32'h104, 32'h108.
- Cold BTB: predict_taken=1 constantly, empty BTB -> PC increments by 4 each cycle and pred_taken_out=0.
- Train and hit:
  - Update btb_update_PC=32'h108, btb_update_target=32'h200, then restart fetch at 32'h100.
  - At PC 32'h108 with predict_taken=1 -> pred_taken_out=1, pred_target=32'h200, next fetch_PC=32'h200.
  - Same with predict_taken=0 -> next fetch_PC=32'h10C.
- Alias and tag mismatch: after the entry for 32'h108, fetch 32'h208 (same index, different tag) -> miss, next 32'h20C. Then update with 32'h208 -> 32'h300; fetch 32'h108 -> miss (entry overwritten).
- Priority: at PC 32'h108 with a BTB hit, apply stall=1 and redirect_valid=1, redirect_PC=32'h403 -> next fetch_PC=32'h400. Stall alone -> PC held at 32'h108 for each stalled cycle.
- Same-cycle update/lookup: fetch at 32'h108 while updating 32'h108 -> 32'h200 in the same cycle -> this cycle misses (next 32'h10C). Refetching 32'h108 later hits. Wrap: fetch at 32'hFFFF_FFFC with no hit -> next 32'h0.
